mod_memstage_sb: RTL
====================

# mod_memstage_sb

Parametrised, clocked memory stage between the ID/MEM and MEM/EX pipeline registers. It accepts one instruction per handshake and passes non-memory ops through. Loads go through a single-outstanding request FSM. Stores are posted into a SB_DEPTH-entry store buffer that drains to the data memory port in the background, so stores retire to EX without waiting for memory.

## Interface
- DATA_W, 64, data and store-data width.
- ADDR_W, 64, memory address width.
- PAYLOAD_W, 32, opaque pipeline payload (opcode, reg/rm bytes, dep) carried to EX unchanged.
- SB_DEPTH, 4, store-buffer entries; power of two, ≥2.

- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  ID/MEM holds an instruction.
- in_ready  out  1  instruction accepted when in_valid && in_ready.
- in_op  in  2  00 pass, 01 load, 10 store, 11 reserved (treated as pass).
- in_addr  in  ADDR_W  effective address.
- in_wdata  in  DATA_W  store data / pass-through operand.
- in_payload  in  PAYLOAD_W  carried payload.
- in_sim_end  in  1  end-of-simulation marker.
- out_valid  out  1  MEM/EX entry valid.
- out_ready  in  1  EX consumes when out_valid && out_ready.
- out_data  out  DATA_W  load result, else in_wdata.
- out_payload  out  PAYLOAD_W  carried payload.
- out_sim_end  out  1  marker, asserted only once the store buffer is empty.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store drain, 0 = load.
- mem_addr  out  ADDR_W  request address.
- mem_wdata  out  DATA_W  store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  DATA_W  load data.
- sb_count  out  $clog2(SB_DEPTH)+1  occupied store-buffer entries.

## Operation
- Reset: all outputs 0, FSM IDLE, store buffer empty.
- FSM states: IDLE, LD_REQ, LD_WAIT, END_WAIT.
- Output register (one entry). A slot is free when !out_valid || out_ready.
- in_ready = (FSM==IDLE) && slot free && !(in_op==store && sb full).
- Pass op: accepted in IDLE, loaded into the output register.
- Store: pushed into the store buffer tail and loaded into the output register in the same cycle (store retires).
- Load:
  - IDLE→LD_REQ, but only once the store buffer is empty (without forwarding); until then the FSM holds IDLE with the load latched and in_ready=0.
  - LD_REQ: mem_req=1, mem_we=0 until mem_gnt, then →LD_WAIT.
  - LD_WAIT: on mem_rvalid, capture mem_rdata into the output register and →IDLE.
- sim_end: accept → END_WAIT. Wait for sb_count==0, then present on the output with out_sim_end=1 → IDLE.
- Drain:
  - When the FSM is not in LD_REQ and the buffer is non-empty, drive the head entry with mem_req=1, mem_we=1.
  - Pop on mem_gnt.
  - A load request takes port priority over drain.
- Push and pop in the same cycle: count unchanged, pointers wrap modulo SB_DEPTH.
- mem_rvalid outside LD_WAIT is ignored, including a stale response after reset.
- The output register holds its value while out_valid && !out_ready.

## Timing
- Pass/store: accepted at cycle N → out_valid at N+1.
- Load with an empty buffer and gnt/rvalid zero-wait: accept N, mem_req N+1, rvalid N+2, out_valid N+3.
- Store drain: head visible on the memory port the cycle after push at the earliest.
- A full buffer stalls in_ready for stores only while full. A pop at cycle N re-opens in_ready at N+1.
- Reset asserted mid-load or mid-drain: immediate return to reset values. In-flight memory transactions are abandoned.

## Configuration
- MEMSTAGE_LDFWD_EN defined:
  - A load compares in_addr against all valid buffer entries; the youngest match supplies out_data at N+1 with no memory request.
  - A miss bypasses pending stores and issues immediately, without waiting for the buffer to empty.
- MEMSTAGE_LDFWD_EN undefined: loads always wait for an empty buffer. No compare logic is built.

## Structure
- Shared package memstage_pkg:
  - mem_op_e (PASS/LOAD/STORE)
  - memstage_state_e
  - ID_MEM and MEM_EX packed structs, sized from package constants matching the defaults
- Sub-module mod_store_buffer:
  - circular FIFO with head/tail/count
  - push/pop
  - youngest-match address CAM, compiled only under MEMSTAGE_LDFWD_EN

## Test plan
- Pass op, payload 0xDEAD_BEEF, out_ready=1 → out_valid one cycle later, identical payload, mem_req never asserted.
- Store to 0x100, data 0x55, then load from 0x200, memory returns 0x77 one cycle after gnt:
  - store retires at N+1, drain write seen on the port;
  - without forwarding, the load's mem_req waits for the buffer to empty;
  - out_data=0x77.
- Five back-to-back stores, SB_DEPTH=4, mem_gnt=0 → in_ready low after four; sb_count=4. Releasing gnt for one cycle re-opens in_ready the next cycle; pointer wrap verified.
- With MEMSTAGE_LDFWD_EN: stores 0x1→0x40 then 0x2→0x40, then load 0x40 → out_data=0x2 at N+1, no load mem_req.
- sim_end with 3 stores pending → out_sim_end rises only after the third pop; out_valid held under out_ready=0.
- Reset asserted in LD_WAIT, then a stale mem_rvalid → ignored; all outputs stay 0 and sb_count=0.

Source files
------------

// File: rtl/memstage_pkg.sv
// rtl/memstage_pkg.sv - shared op/state types and default widths for the memory stage
package memstage_pkg;

   localparam int MS_DATA_W    = 64;
   localparam int MS_ADDR_W    = 64;
   localparam int MS_PAYLOAD_W = 32;
   localparam int MS_SB_DEPTH  = 4;

   typedef enum logic [1:0] {
      OP_PASS  = 2'b00,
      OP_LOAD  = 2'b01,
      OP_STORE = 2'b10
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LD_REQ,
      ST_LD_WAIT,
      ST_END_WAIT
   } memstage_state_e;

   typedef struct packed {
      logic [1:0]              op;
      logic [MS_ADDR_W-1:0]    addr;
      logic [MS_DATA_W-1:0]    wdata;
      logic [MS_PAYLOAD_W-1:0] payload;
      logic                    sim_end;
   } id_mem_t;

   typedef struct packed {
      logic [MS_DATA_W-1:0]    data;
      logic [MS_PAYLOAD_W-1:0] payload;
      logic                    sim_end;
   } mem_ex_t;

   // The reserved encoding 2'b11 matches no kind, so it falls through as a pass op.
   function automatic logic op_is(input logic [1:0] op, input mem_op_e kind);
      return op == kind;
   endfunction

endpackage

// File: rtl/mod_store_buffer.sv
// rtl/mod_store_buffer.sv - circular store buffer; youngest-match lookup under MEMSTAGE_LDFWD_EN
// Callers push only when not full and pop only when not empty.
module mod_store_buffer
   import memstage_pkg::*;
#(
   parameter int DATA_W = MS_DATA_W,
   parameter int ADDR_W = MS_ADDR_W,
   parameter int DEPTH  = MS_SB_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [ADDR_W-1:0]        push_addr,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   output logic [ADDR_W-1:0]        head_addr,
   output logic [DATA_W-1:0]        head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
`ifdef MEMSTAGE_LDFWD_EN
   ,
   input  logic [ADDR_W-1:0]        lk_addr,
   output logic                     lk_hit,
   output logic [DATA_W-1:0]        lk_data
`endif
);

   localparam int PW = $clog2(DEPTH);

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [PW-1:0]     head_q, head_d;
   logic [PW-1:0]     tail_q, tail_d;
   logic [PW:0]       count_q, count_d;

   always_comb begin
      addr_d  = addr_q;
      data_d  = data_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) begin
         addr_d[tail_q] = push_addr;
         data_d[tail_q] = push_data;
         tail_d         = tail_q + PW'(1);
      end
      if (pop) begin
         head_d = head_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         addr_q  <= addr_d;
         data_q  <= data_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign head_addr = addr_q[head_q];
   assign head_data = data_q[head_q];
   assign count     = count_q;
   assign full      = (count_q == (PW+1)'(DEPTH));
   assign empty     = (count_q == '0);

`ifdef MEMSTAGE_LDFWD_EN
   logic [PW-1:0] lk_idx;

   // Walk oldest to youngest so the last hit left standing is the youngest store.
   always_comb begin
      lk_hit  = 1'b0;
      lk_data = '0;
      lk_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         lk_idx = head_q + PW'(i);
         if (((PW+1)'(i) < count_q) && (addr_q[lk_idx] == lk_addr)) begin
            lk_hit  = 1'b1;
            lk_data = data_q[lk_idx];
         end
      end
   end
`endif

endmodule

// File: rtl/mod_memstage_sb.sv
// rtl/mod_memstage_sb.sv - memory stage with posted-store buffer and single-outstanding loads
// MEMSTAGE_LDFWD_EN enables store-to-load forwarding and lets load misses bypass pending stores.
module mod_memstage_sb
   import memstage_pkg::*;
#(
   parameter int DATA_W    = MS_DATA_W,
   parameter int ADDR_W    = MS_ADDR_W,
   parameter int PAYLOAD_W = MS_PAYLOAD_W,
   parameter int SB_DEPTH  = MS_SB_DEPTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [1:0]                in_op,
   input  logic [ADDR_W-1:0]         in_addr,
   input  logic [DATA_W-1:0]         in_wdata,
   input  logic [PAYLOAD_W-1:0]      in_payload,
   input  logic                      in_sim_end,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic [PAYLOAD_W-1:0]      out_payload,
   output logic                      out_sim_end,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic                      mem_gnt,
   input  logic                      mem_rvalid,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic [$clog2(SB_DEPTH):0] sb_count
);

   memstage_state_e        state_q, state_d;
   logic                   ld_pend_q, ld_pend_d;
   logic [ADDR_W-1:0]      ld_addr_q, ld_addr_d;
   logic [PAYLOAD_W-1:0]   hold_payload_q, hold_payload_d;
   logic [DATA_W-1:0]      hold_data_q, hold_data_d;
   logic                   out_valid_q, out_valid_d;
   logic [DATA_W-1:0]      out_data_q, out_data_d;
   logic [PAYLOAD_W-1:0]   out_payload_q, out_payload_d;
   logic                   out_sim_end_q, out_sim_end_d;

   logic slot_free, is_load, is_store, in_ready_c, accept, ld_req, drain;
   logic sb_push, sb_pop, sb_full, sb_empty;
   logic [ADDR_W-1:0] sb_head_addr;
   logic [DATA_W-1:0] sb_head_data;
`ifdef MEMSTAGE_LDFWD_EN
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;
`endif

   mod_store_buffer #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (SB_DEPTH)
   ) u_sb (
      .clk       (clk),
      .reset     (reset),
      .push      (sb_push),
      .push_addr (in_addr),
      .push_data (in_wdata),
      .pop       (sb_pop),
      .head_addr (sb_head_addr),
      .head_data (sb_head_data),
      .count     (sb_count),
      .full      (sb_full),
      .empty     (sb_empty)
`ifdef MEMSTAGE_LDFWD_EN
      ,
      .lk_addr   (in_addr),
      .lk_hit    (fwd_hit),
      .lk_data   (fwd_data)
`endif
   );

   always_comb begin
      slot_free  = !out_valid_q || out_ready;
      is_load    = op_is(in_op, OP_LOAD);
      is_store   = op_is(in_op, OP_STORE);
      in_ready_c = (state_q == ST_IDLE) && !ld_pend_q && slot_free && !(is_store && sb_full);
      accept     = in_valid && in_ready_c;
      ld_req     = (state_q == ST_LD_REQ);
      drain      = !ld_req && !sb_empty;
      sb_push    = accept && !in_sim_end && is_store;
      sb_pop     = drain && mem_gnt;

      state_d        = state_q;
      ld_pend_d      = ld_pend_q;
      ld_addr_d      = ld_addr_q;
      hold_payload_d = hold_payload_q;
      hold_data_d    = hold_data_q;
      out_valid_d    = out_valid_q;
      out_data_d     = out_data_q;
      out_payload_d  = out_payload_q;
      out_sim_end_d  = out_sim_end_q;

      if (out_valid_q && out_ready) begin
         out_valid_d   = 1'b0;
         out_sim_end_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (ld_pend_q && sb_empty) begin
               ld_pend_d = 1'b0;
               state_d   = ST_LD_REQ;
            end else if (accept) begin
               if (in_sim_end) begin
                  hold_payload_d = in_payload;
                  hold_data_d    = in_wdata;
                  state_d        = ST_END_WAIT;
               end else if (is_load) begin
                  ld_addr_d      = in_addr;
                  hold_payload_d = in_payload;
`ifdef MEMSTAGE_LDFWD_EN
                  if (fwd_hit) begin
                     out_valid_d   = 1'b1;
                     out_data_d    = fwd_data;
                     out_payload_d = in_payload;
                     out_sim_end_d = 1'b0;
                  end else begin
                     state_d = ST_LD_REQ;
                  end
`else
                  // Without forwarding a load must not overtake any buffered store.
                  if (sb_empty) begin
                     state_d = ST_LD_REQ;
                  end else begin
                     ld_pend_d = 1'b1;
                  end
`endif
               end else begin
                  out_valid_d   = 1'b1;
                  out_data_d    = in_wdata;
                  out_payload_d = in_payload;
                  out_sim_end_d = 1'b0;
               end
            end
         end
         ST_LD_REQ: begin
            if (mem_gnt) begin
               state_d = ST_LD_WAIT;
            end
         end
         ST_LD_WAIT: begin
            if (mem_rvalid) begin
               out_valid_d   = 1'b1;
               out_data_d    = mem_rdata;
               out_payload_d = hold_payload_q;
               out_sim_end_d = 1'b0;
               state_d       = ST_IDLE;
            end
         end
         ST_END_WAIT: begin
            if (sb_empty) begin
               out_valid_d   = 1'b1;
               out_data_d    = hold_data_q;
               out_payload_d = hold_payload_q;
               out_sim_end_d = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         ld_pend_q      <= 1'b0;
         ld_addr_q      <= '0;
         hold_payload_q <= '0;
         hold_data_q    <= '0;
         out_valid_q    <= 1'b0;
         out_data_q     <= '0;
         out_payload_q  <= '0;
         out_sim_end_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         ld_pend_q      <= ld_pend_d;
         ld_addr_q      <= ld_addr_d;
         hold_payload_q <= hold_payload_d;
         hold_data_q    <= hold_data_d;
         out_valid_q    <= out_valid_d;
         out_data_q     <= out_data_d;
         out_payload_q  <= out_payload_d;
         out_sim_end_q  <= out_sim_end_d;
      end
   end

   // in_ready is the only combinational output that would otherwise be high while reset is held.
   assign in_ready    = in_ready_c && !reset;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_payload = out_payload_q;
   assign out_sim_end = out_sim_end_q;
   assign mem_req     = ld_req || drain;
   assign mem_we      = drain;
   assign mem_addr    = ld_req ? ld_addr_q : (drain ? sb_head_addr : '0);
   assign mem_wdata   = drain ? sb_head_data : '0;

endmodule
